uart_rx_fifo: RTL

//  Synthesisable, parametrised UART receiver with a receive FIFO, used on the soc UART rx path.

---
 rtl/uart_rx_fifo.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (mid-bit sampling, start-glitch rejection, framing/overrun detection) feeding a
// first-word-fall-through receive FIFO. Optional even-parity bit: define UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              uart_rx,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  output logic [DATA_BITS-1:0]              rx_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_level,
  output logic                              busy,
  output logic                              frame_err,
  output logic                              overrun,
  output logic                              parity_err
);

  localparam int unsigned DivW = $clog2(CLKS_PER_BIT);
  localparam int unsigned CntW = $clog2(DATA_BITS);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  localparam logic [DivW-1:0] DivHalf = DivW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [DivW-1:0] DivFull = DivW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_BITS - 1);
  localparam logic [PtrW:0]   LvlFull = (PtrW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StStop   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] StParity = 3'd3;
`endif

  logic                 rx_meta_q, rx_sync_q;
  logic [2:0]           state_q, state_d;
  logic [DivW-1:0]      div_q, div_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic                 push;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
`endif

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW:0]        wptr_q, rptr_q, level;
  logic                 full, pop, wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    push         = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
`endif
    case (state_q)
      StIdle: begin
        if (!rx_sync_q) begin
          state_d = StStart;
          div_d   = '0;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (div_q == DivHalf) begin
          div_d   = '0;
          state_d = rx_sync_q ? StIdle : StData;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StData: begin
        if (div_q == DivFull) begin
          div_d   = '0;
          shreg_d = {rx_sync_q, shreg_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (div_q == DivFull) begin
          div_d     = '0;
          par_bad_d = rx_sync_q != ^shreg_q;
          state_d   = StStop;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (div_q == DivFull) begin
          div_d       = '0;
          state_d     = StIdle;
          frame_err_d = !rx_sync_q;
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad_q;
          push         = rx_sync_q && !par_bad_q;
`else
          push         = rx_sync_q;
`endif
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      div_q        <= '0;
      cnt_q        <= '0;
      shreg_q      <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_bad_q <= 1'b0;
    else        par_bad_q <= par_bad_d;
  end
`endif

  // Pointers carry one wrap bit beyond the address so full and empty differ.
  assign level     = wptr_q - rptr_q;
  assign full      = level == LvlFull;
  assign rx_valid  = level != '0;
  assign pop       = rx_valid && rx_ready;
  assign wr_en     = push && (!full || pop);
  assign overrun_d = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wptr_q[PtrW-1:0]] <= shreg_q;
        wptr_q                  <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
    end
  end

  assign rx_data    = mem_q[rptr_q[PtrW-1:0]];
  assign rx_level   = level;
  assign busy       = state_q != StIdle;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
